mipi_phy_ser: RTL and testbench
===============================

MIPI_PHY_SER -- requirements
Module: mipi_phy_ser

Interface
REQ-001 SHALL have parameter LPX_CYCLES, default 4: cycles of LP-01 request state.
REQ-002 SHALL have parameter PREP_CYCLES, default 4: cycles of LP-00 with HS driver off.
REQ-003 SHALL have parameter ZERO_CYCLES, default 8: cycles of HS 0x00 before the sync byte.
REQ-004 SHALL have parameter TRAIL_CYCLES, default 4: cycles of HS trail byte after the last data byte.
REQ-005 SHALL have port clk, input, 1: byte clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port din, input, 8: payload byte.
REQ-008 SHALL have port din_valid, input, 1: din is valid.
REQ-009 SHALL have port din_last, input, 1: din is the final byte of the packet.
REQ-010 SHALL have port din_ready, output, 1: byte accepted this cycle when din_valid is also high.
REQ-011 SHALL have port lp_gap, input, 8: minimum LP-11 cycles between packets.
REQ-012 SHALL have port q, output, 8: parallel HS byte to the serializer, MSB sent first.
REQ-013 SHALL have port hs_en, output, 1: enables the HS differential driver.
REQ-014 SHALL have ports lp_p and lp_n, output, 1 each: LP line levels.
REQ-015 SHALL have port busy, output, 1: high whenever not IDLE.
REQ-016 SHALL have port underrun, output, 1: one-cycle pulse on a mid-packet data starvation.

Function
REQ-017 SHALL implement states IDLE, LPX, PREP, ZERO, SYNC, DATA, TRAIL, EXIT, each with registered outputs.
REQ-018 IDLE: lp=11, hs_en=0, q=0x00; the gap counter increments and saturates at 255.
REQ-019 SHALL leave IDLE for LPX when din_valid=1 and gap counter >= lp_gap; lp_gap=0 permits an immediate start.
REQ-020 LPX: lp=01 for LPX_CYCLES; PREP: lp=00, hs_en=0 for PREP_CYCLES.
REQ-021 ZERO: lp=00, hs_en=1, q=0x00 for ZERO_CYCLES; SYNC: q=0xB8 for exactly one cycle.
REQ-022 SHALL place accepted bytes on q in acceptance order, with no bubbles, in the cycles immediately after the 0xB8 cycle.
REQ-023 SHALL assert din_ready only in the cycles whose accepted byte appears on q at the next edge; an accepted byte appears on q one cycle after acceptance.
REQ-024 SHALL drop din_ready in the cycle after the byte with din_last=1 is accepted, then enter TRAIL.
REQ-025 If din_ready=1 and din_valid=0 before din_last is accepted, SHALL pulse underrun for one cycle and enter TRAIL next cycle; a packet with zero data bytes is legal.
REQ-026 TRAIL: hs_en=1; q = 8 copies of the inverse of bit0 of the last transmitted byte (0xB8 if no data), for TRAIL_CYCLES.
REQ-027 EXIT: hs_en=0, lp=11 for one cycle, gap counter cleared, then IDLE.
REQ-028 SHALL treat din_valid/din_last outside din_ready cycles as don't-care and SHALL NOT consume them.
REQ-029 All counters SHALL be wide enough for their parameter; a parameter value of 0 SHALL be treated as 1.

Reset
REQ-030 On reset SHALL enter IDLE with lp_p=1, lp_n=1, hs_en=0, q=0x00, din_ready=0, busy=0, underrun=0, gap counter=0.
REQ-031 Reset asserted mid-packet SHALL abort the packet with no trail; the next packet waits at least lp_gap cycles.

Configuration
REQ-032 With macro MIPI_TX_POLARITY_EN defined, SHALL add input md_polarity (1 bit), and every q byte in ZERO, SYNC, DATA and TRAIL SHALL be XORed with {8{md_polarity}}.
REQ-033 Without MIPI_TX_POLARITY_EN, port md_polarity SHALL be absent and q SHALL be uninverted.

Verification
REQ-034 Defaults, lp_gap=0, 3 bytes 0x11,0x22,0x33 presented back-to-back -> lp 11→01(4)→00; hs_en rises; q = 0x00×8, 0xB8, 0x11, 0x22, 0x33, 0x00×4 (0x33 bit0=1); then lp=11.
REQ-035 lp_gap=10, second packet pending at EXIT -> exactly 10 IDLE cycles of LP-11 before lp=01.
REQ-036 din_valid dropped after 2 of 4 bytes -> one underrun pulse; trail follows the 2nd byte; remaining bytes are not consumed.
REQ-037 Reset pulsed during DATA -> next cycle lp=11, hs_en=0, q=0x00, busy=0.
REQ-038 MIPI_TX_POLARITY_EN defined, md_polarity=1, single byte 0x0F -> q = 0xFF×8, 0x47, 0xF0, then trail 0xFF×4.

Source files
------------

// File: rtl/mipi_phy_ser.sv
// MIPI D-PHY single-lane HS transmit sequencer: LP-01/LP-00 entry, HS zero/sync, data, trail, exit.
// Optional MIPI_TX_POLARITY_EN adds md_polarity, which inverts every HS byte driven on q.
module mipi_phy_ser #(
    parameter int unsigned LPX_CYCLES   = 4,
    parameter int unsigned PREP_CYCLES  = 4,
    parameter int unsigned ZERO_CYCLES  = 8,
    parameter int unsigned TRAIL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    input  logic [7:0] lp_gap,
`ifdef MIPI_TX_POLARITY_EN
    input  logic       md_polarity,
`endif
    output logic [7:0] q,
    output logic       hs_en,
    output logic       lp_p,
    output logic       lp_n,
    output logic       busy,
    output logic       underrun
);

    localparam int unsigned LpxN   = (LPX_CYCLES == 0) ? 1 : LPX_CYCLES;
    localparam int unsigned PrepN  = (PREP_CYCLES == 0) ? 1 : PREP_CYCLES;
    localparam int unsigned ZeroN  = (ZERO_CYCLES == 0) ? 1 : ZERO_CYCLES;
    localparam int unsigned TrailN = (TRAIL_CYCLES == 0) ? 1 : TRAIL_CYCLES;
    localparam int unsigned MaxA   = (LpxN > PrepN) ? LpxN : PrepN;
    localparam int unsigned MaxB   = (ZeroN > TrailN) ? ZeroN : TrailN;
    localparam int unsigned MaxN   = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW   = (MaxN < 2) ? 1 : $clog2(MaxN);

    typedef enum logic [2:0] {
        StIdle, StLpx, StPrep, StZero, StSync, StData, StTrail, StExit
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      gap_q, gap_d;
    logic            lastb0_q, lastb0_d;
    logic            ready_q, ready_d;
    logic            underrun_q, underrun_d;
    logic [7:0]      byte_q, byte_d;
    logic            hs_en_q, hs_en_d;
    logic            lp_p_q, lp_p_d;
    logic            lp_n_q, lp_n_d;
    logic            busy_q, busy_d;
    logic [7:0]      raw_d;
    logic            pol;

`ifdef MIPI_TX_POLARITY_EN
    assign pol = md_polarity;
`else
    assign pol = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        lastb0_d   = lastb0_q;
        ready_d    = 1'b0;
        underrun_d = 1'b0;
        raw_d      = 8'h00;
        unique case (state_q)
            StIdle: begin
                if (gap_q != 8'hFF) gap_d = gap_q + 8'd1;
                // The current IDLE cycle counts toward the gap: lp_gap=N gives exactly N IDLE cycles.
                if (din_valid && (({1'b0, gap_q} + 9'd1) >= {1'b0, lp_gap})) begin
                    state_d = StLpx;
                    cnt_d   = CntW'(LpxN - 1);
                end
            end
            StLpx: begin
                if (cnt_q == '0) begin
                    state_d = StPrep;
                    cnt_d   = CntW'(PrepN - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StPrep: begin
                if (cnt_q == '0) begin
                    state_d = StZero;
                    cnt_d   = CntW'(ZeroN - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StZero: begin
                if (cnt_q == '0) begin
                    state_d  = StSync;
                    ready_d  = 1'b1;
                    lastb0_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSync, StData: begin
                if (!ready_q) begin
                    state_d = StTrail;
                    cnt_d   = CntW'(TrailN - 1);
                end else if (din_valid) begin
                    state_d  = StData;
                    ready_d  = !din_last;
                    lastb0_d = din[0];
                    raw_d    = din;
                end else begin
                    state_d    = StTrail;
                    cnt_d      = CntW'(TrailN - 1);
                    underrun_d = 1'b1;
                end
            end
            StTrail: begin
                if (cnt_q == '0) begin
                    state_d = StExit;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StExit: begin
                state_d = StIdle;
                gap_d   = 8'h00;
            end
        endcase

        case (state_d)
            StSync:  raw_d = 8'hB8;
            StTrail: raw_d = {8{~lastb0_d}};
            default: ;
        endcase

        hs_en_d = state_d inside {StZero, StSync, StData, StTrail};
        byte_d  = raw_d ^ {8{pol & hs_en_d}};
        lp_p_d  = (state_d == StIdle) || (state_d == StExit);
        lp_n_d  = lp_p_d || (state_d == StLpx);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            gap_q      <= 8'h00;
            lastb0_q   <= 1'b0;
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
            byte_q     <= 8'h00;
            hs_en_q    <= 1'b0;
            lp_p_q     <= 1'b1;
            lp_n_q     <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            lastb0_q   <= lastb0_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
            byte_q     <= byte_d;
            hs_en_q    <= hs_en_d;
            lp_p_q     <= lp_p_d;
            lp_n_q     <= lp_n_d;
            busy_q     <= busy_d;
        end
    end

    assign din_ready = ready_q;
    assign underrun  = underrun_q;
    assign q         = byte_q;
    assign hs_en     = hs_en_q;
    assign lp_p      = lp_p_q;
    assign lp_n      = lp_n_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mipi_phy_ser.sv
// Directed bench for mipi_phy_ser: vector table for a full packet and a zero-byte packet,
// hand sequences for lp_gap spacing, underrun, mid-packet reset and (if enabled) polarity.
module tb_mipi_phy_ser;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       din_last;
    logic       din_ready;
    logic [7:0] lp_gap;
    logic [7:0] q;
    logic       hs_en;
    logic       lp_p;
    logic       lp_n;
    logic       busy;
    logic       underrun;
    logic       pol;
    int         n_cmp = 0;
    int         n_bad = 0;

`ifdef MIPI_TX_POLARITY_EN
    logic md_polarity;
    assign md_polarity = pol;
`endif

    always #5 clk = ~clk;

    mipi_phy_ser dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_last  (din_last),
        .din_ready (din_ready),
        .lp_gap    (lp_gap),
`ifdef MIPI_TX_POLARITY_EN
        .md_polarity (md_polarity),
`endif
        .q         (q),
        .hs_en     (hs_en),
        .lp_p      (lp_p),
        .lp_n      (lp_n),
        .busy      (busy),
        .underrun  (underrun)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Packed as {lp_p, lp_n, hs_en, busy, din_ready, underrun, q}.
    function automatic logic [13:0] pk(input logic p, input logic n, input logic h, input logic b,
                                       input logic r, input logic u, input logic [7:0] qq);
        return {p, n, h, b, r, u, qq};
    endfunction

    function automatic logic [7:0] hsb(input logic [7:0] b);
        return b ^ {8{pol}};
    endfunction

    function automatic logic [13:0] e_idle();
        return pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endfunction
    function automatic logic [13:0] e_lpx();
        return pk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endfunction
    function automatic logic [13:0] e_prep();
        return pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endfunction
    function automatic logic [13:0] e_zero();
        return pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, hsb(8'h00));
    endfunction
    function automatic logic [13:0] e_sync();
        return pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, hsb(8'hB8));
    endfunction
    function automatic logic [13:0] e_data(input logic [7:0] b, input logic r);
        return pk(1'b0, 1'b0, 1'b1, 1'b1, r, 1'b0, hsb(b));
    endfunction
    function automatic logic [13:0] e_trail(input logic [7:0] b, input logic u);
        return pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, u, hsb(b));
    endfunction
    function automatic logic [13:0] e_exit();
        return pk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endfunction

    task automatic add(input int n, input logic v, input logic [7:0] d, input logic l,
                       input logic [13:0] exp);
        vec_t r;
        r.v   = v;
        r.d   = d;
        r.l   = l;
        r.exp = exp;
        for (int i = 0; i < n; i++) tbl.push_back(r);
    endtask

    // Compare this cycle's outputs, then advance to 1 time unit after the next rising edge.
    task automatic cyc(input string nm, input logic [13:0] exp);
        logic [13:0] act;
        act = {lp_p, lp_n, hs_en, busy, din_ready, underrun, q};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got lp=%b%b hs=%b busy=%b rdy=%b und=%b q=%02h, want lp=%b%b hs=%b busy=%b rdy=%b und=%b q=%02h",
                     nm, act[13], act[12], act[11], act[10], act[9], act[8], act[7:0],
                     exp[13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preamble(input string nm, input int nlpx);
        for (int i = 0; i < nlpx; i++) cyc({nm, "_lpx"}, e_lpx());
        for (int i = 0; i < 4; i++) cyc({nm, "_prep"}, e_prep());
        for (int i = 0; i < 8; i++) cyc({nm, "_zero"}, e_zero());
    endtask

    initial begin
        pol       = 1'b0;
        reset     = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;
        din_last  = 1'b0;
        lp_gap    = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", e_idle());
        reset = 1'b0;

        // Three-byte packet, bytes held valid through the preamble and not consumed early.
        add(1, 1'b1, 8'h11, 1'b0, e_idle());
        add(4, 1'b1, 8'h11, 1'b0, e_lpx());
        add(4, 1'b1, 8'h11, 1'b0, e_prep());
        add(8, 1'b1, 8'h11, 1'b0, e_zero());
        add(1, 1'b1, 8'h11, 1'b0, e_sync());
        add(1, 1'b1, 8'h22, 1'b0, e_data(8'h11, 1'b1));
        add(1, 1'b1, 8'h33, 1'b1, e_data(8'h22, 1'b1));
        add(1, 1'b0, 8'h00, 1'b0, e_data(8'h33, 1'b0));
        add(4, 1'b0, 8'h00, 1'b0, e_trail(8'h00, 1'b0));
        add(1, 1'b0, 8'h00, 1'b0, e_exit());
        add(2, 1'b0, 8'h00, 1'b0, e_idle());
        // Zero-byte packet: starved at SYNC, trail derived from 0xB8.
        add(1, 1'b1, 8'h00, 1'b0, e_idle());
        add(4, 1'b0, 8'h00, 1'b0, e_lpx());
        add(4, 1'b0, 8'h00, 1'b0, e_prep());
        add(8, 1'b0, 8'h00, 1'b0, e_zero());
        add(1, 1'b0, 8'h00, 1'b0, e_sync());
        add(1, 1'b0, 8'h00, 1'b0, e_trail(8'hFF, 1'b1));
        add(3, 1'b0, 8'h00, 1'b0, e_trail(8'hFF, 1'b0));
        add(1, 1'b0, 8'h00, 1'b0, e_exit());
        add(1, 1'b0, 8'h00, 1'b0, e_idle());

        foreach (tbl[i]) begin
            din_valid = tbl[i].v;
            din       = tbl[i].d;
            din_last  = tbl[i].l;
            cyc($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Single-byte packet; lp_gap=10 with the next packet already pending at EXIT.
        din_valid = 1'b1;
        din       = 8'h5A;
        din_last  = 1'b1;
        cyc("g_idle", e_idle());
        preamble("g", 4);
        cyc("g_sync", e_sync());
        lp_gap   = 8'd10;
        din      = 8'hA1;
        din_last = 1'b0;
        cyc("g_data", e_data(8'h5A, 1'b0));
        for (int i = 0; i < 4; i++) cyc("g_trail", e_trail(8'hFF, 1'b0));
        cyc("g_exit", e_exit());
        for (int i = 0; i < 10; i++) cyc("gap_idle", e_idle());
        cyc("gap_lpx", e_lpx());

        // Underrun after two of four bytes; the third byte must lead the next packet.
        preamble("u", 3);
        cyc("u_sync", e_sync());
        din = 8'hA2;
        cyc("u_d1", e_data(8'hA1, 1'b1));
        din_valid = 1'b0;
        cyc("u_d2", e_data(8'hA2, 1'b1));
        din_valid = 1'b1;
        din       = 8'hA3;
        cyc("u_und", e_trail(8'hFF, 1'b1));
        for (int i = 0; i < 3; i++) cyc("u_trail", e_trail(8'hFF, 1'b0));
        cyc("u_exit", e_exit());
        for (int i = 0; i < 10; i++) cyc("u_gap", e_idle());
        cyc("r_lpx", e_lpx());

        // Reset during DATA: no trail, and lp_gap is re-enforced from zero.
        preamble("r", 3);
        cyc("r_sync", e_sync());
        din      = 8'hA4;
        din_last = 1'b1;
        reset    = 1'b1;
        cyc("r_d1", e_data(8'hA3, 1'b1));
        reset = 1'b0;
        cyc("r_rst", e_idle());
        for (int i = 0; i < 9; i++) cyc("r_gap", e_idle());
        cyc("r2_lpx", e_lpx());
        preamble("r2", 3);
        cyc("r2_sync", e_sync());
        din_valid = 1'b0;
        din_last  = 1'b0;
        cyc("r2_data", e_data(8'hA4, 1'b0));
        for (int i = 0; i < 4; i++) cyc("r2_trail", e_trail(8'hFF, 1'b0));
        cyc("r2_exit", e_exit());
        cyc("r2_idle", e_idle());

`ifdef MIPI_TX_POLARITY_EN
        pol       = 1'b1;
        lp_gap    = 8'd0;
        repeat (10) cyc("p_wait", e_idle());
        din_valid = 1'b1;
        din       = 8'h0F;
        din_last  = 1'b1;
        cyc("p_idle", e_idle());
        preamble("p", 4);
        cyc("p_sync", e_sync());
        din_valid = 1'b0;
        din_last  = 1'b0;
        cyc("p_data", e_data(8'h0F, 1'b0));
        for (int i = 0; i < 4; i++) cyc("p_trail", e_trail(8'h00, 1'b0));
        cyc("p_exit", e_exit());
        cyc("p_idle2", e_idle());
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
